chunk_serial_adder: RTL and testbench
=====================================

Name: chunk_serial_adder

Overview:
Multi-cycle parametrised adder/subtractor that reuses a CHUNK-bit ripple slice of full-adder cells over WIDTH/CHUNK clock cycles. It is the sequential successor of the team's 1-bit full adder: it supports configurable width and slice size, a subtract mode, and a start/busy/done handshake. It sits beside the ALU datapath, where area matters more than single-cycle latency.

Parameters:
WIDTH, 32, operand/result width in bits; must be an integer multiple of CHUNK.
CHUNK, 4, bits processed per clock cycle; 1 <= CHUNK <= WIDTH.

Ports:
clk  input  1  system clock, all state updates on rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  request a new operation; sampled only when busy=0.
sub  input  1  0 = add, 1 = subtract (a - b); sampled with start.
cin  input  1  carry-in for add mode; ignored when sub=1.
a  input  WIDTH  operand A; sampled with start.
b  input  WIDTH  operand B; sampled with start.
sum  output  WIDTH  result; valid when done=1, held until next accepted start.
cout  output  1  final carry-out (sub mode: 1 = no borrow); same validity as sum.
overflow  output  1  signed overflow flag (see Optional Feature).
busy  output  1  high while an operation is in progress.
done  output  1  single-cycle pulse, result valid.

Behaviour:
- Reset (async, rst=1): state=IDLE; sum=0, cout=0, overflow=0, busy=0, done=0; chunk index=0; internal operand/carry registers cleared. Outputs stay at these values while rst is held.
- States: IDLE, RUN. N = WIDTH/CHUNK.
- IDLE, start=1 at edge E0: latch a and b; latch b_eff = sub ? ~b : b; latch carry = sub ? 1 : cin. Clear index, go to RUN, busy=1. done is forced 0 on this edge.
- RUN, edge E(k+1), k=0..N-1: compute chunk k = a[k*CHUNK +: CHUNK] + b_eff[...] + carry. Write it into sum[k*CHUNK +: CHUNK]. Carry register = chunk carry-out. Increment index.
- Last chunk edge E(N): cout = final carry; overflow updated; done=1, busy=0, state returns to IDLE.
- Latency: done is high in the cycle following edge E(N), i.e. N cycles after start is sampled. When CHUNK=WIDTH, latency is 1 cycle.
- done is high for exactly one cycle and clears on the next edge unless that edge completes another operation, which is impossible since minimum latency >= 1.
- start in RUN: ignored, with no effect on operands or progress.
- start=1 in the done cycle: accepted, because busy=0. The new operation begins; sum/cout keep the old result until overwritten chunk by chunk.
- During RUN, the sum bits of chunks not yet processed keep their previous values; only done qualifies the result.
- sub and cin are ignored outside the start-acceptance cycle.
- Width rule: results are modulo 2^WIDTH; no sign extension.
- rst asserted mid-RUN: the operation is abandoned immediately, with no done pulse, and all outputs go to reset values.

Optional Feature:
Macro CHUNK_ADDER_OVF_EN.
- Defined: at the final chunk, overflow = carry into MSB XOR carry out of MSB, i.e. signed two's-complement overflow for the effective add. It is registered with cout and held until the next completion.
- Undefined: overflow is tied to constant 0 and no MSB-carry logic is built.

Test Plan:
1. WIDTH=8, CHUNK=2: rst pulse, then start with a=8'hFF, b=8'h01, sub=0, cin=0 -> busy=1 for 4 cycles; done pulses 4 cycles after start with sum=8'h00, cout=1, overflow=0.
2. WIDTH=8, CHUNK=2, sub=1: a=8'h05, b=8'h07 -> sum=8'hFE, cout=0 (borrow). With CHUNK_ADDER_OVF_EN: overflow=0.
3. With CHUNK_ADDER_OVF_EN: a=8'h7F, b=8'h01, sub=0 -> sum=8'h80, overflow=1, cout=0. Without the macro: overflow=0 throughout.
4. start re-pulsed with a=8'h11, b=8'h22 while busy -> ignored; first result still 8'hFF+8'h01 arrives on schedule. Then start in the done cycle with a=8'h11, b=8'h22, cin=1 -> next done gives sum=8'h34.
5. rst asserted 2 cycles into RUN -> all outputs 0 immediately, no done pulse. After release, a fresh start of 8'h10+8'h20 -> sum=8'h30.
6. WIDTH=8, CHUNK=8: a=8'hA5, b=8'h5A, cin=1 -> done 1 cycle after start, sum=8'h00, cout=1.

Source files
------------

// File: rtl/chunk_serial_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple slice reused over WIDTH/CHUNK cycles.
// Optional signed-overflow flag is built only when CHUNK_ADDER_OVF_EN is defined.
module chunk_serial_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow,
  output logic             busy,
  output logic             done
);

  localparam int N    = WIDTH / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_busy;
  logic             r_done;

  logic [31:0]      w_shamt;
  logic [CHUNK-1:0] w_a_chunk;
  logic [CHUNK-1:0] w_b_chunk;
  logic [CHUNK:0]   w_chunk_sum;
  logic [WIDTH-1:0] w_mask;
  logic [WIDTH-1:0] w_chunk_pos;
  logic             w_last;

  // Select the active slice of the latched operands and run it through the ripple slice.
  always_comb begin
    w_shamt     = 32'(r_idx) * 32'(CHUNK);
    w_a_chunk   = CHUNK'(r_a >> w_shamt);
    w_b_chunk   = CHUNK'(r_b >> w_shamt);
    w_chunk_sum = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
    w_mask      = WIDTH'({CHUNK{1'b1}}) << w_shamt;
    w_chunk_pos = WIDTH'(w_chunk_sum[CHUNK-1:0]) << w_shamt;
    w_last      = (r_idx == LAST_IDX);
  end

`ifdef CHUNK_ADDER_OVF_EN
  logic r_overflow;
  logic w_msb_cin;

  // Carry into the MSB recovered from the MSB operand bits and the MSB sum bit.
  always_comb begin
    w_msb_cin = w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1] ^ w_chunk_sum[CHUNK-1];
  end

  // Overflow flag registered together with cout on the final chunk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_overflow <= w_msb_cin ^ w_chunk_sum[CHUNK];
    end else begin
      r_overflow <= r_overflow;
    end
  end

  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? 1'b1 : cin;
            r_idx   <= '0;
            r_busy  <= 1'b1;
            r_state <= RUN;
          end else begin
            r_state <= IDLE;
          end
        end
        RUN: begin
          // Untouched chunks keep their previous value until overwritten.
          r_sum   <= (r_sum & ~w_mask) | w_chunk_pos;
          r_carry <= w_chunk_sum[CHUNK];
          r_idx   <= r_idx + IDXW'(1);
          if (w_last) begin
            r_cout  <= w_chunk_sum[CHUNK];
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= IDLE;
          end else begin
            r_done  <= 1'b0;
            r_state <= RUN;
          end
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_chunk_serial_adder.sv
// Directed table-driven bench for chunk_serial_adder (8x2 and 8x8 configurations).
module tb_chunk_serial_adder;

`ifdef CHUNK_ADDER_OVF_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic       s2_start, s2_sub, s2_cin;
  logic [7:0] s2_a, s2_b, o2_sum;
  logic       o2_cout, o2_ovf, o2_busy, o2_done;
  logic       s8_start, s8_sub, s8_cin;
  logic [7:0] s8_a, s8_b, o8_sum;
  logic       o8_cout, o8_ovf, o8_busy, o8_done;

  chunk_serial_adder #(.WIDTH(8), .CHUNK(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(s2_start), .sub(s2_sub), .cin(s2_cin),
    .a(s2_a), .b(s2_b), .sum(o2_sum), .cout(o2_cout), .overflow(o2_ovf),
    .busy(o2_busy), .done(o2_done)
  );

  chunk_serial_adder #(.WIDTH(8), .CHUNK(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(s8_start), .sub(s8_sub), .cin(s8_cin),
    .a(s8_a), .b(s8_b), .sum(o8_sum), .cout(o8_cout), .overflow(o8_ovf),
    .busy(o8_busy), .done(o8_done)
  );

  typedef struct {
    logic       sub;
    logic       cin;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp_sum;
    logic       exp_cout;
    logic       exp_ovf;
  } vec_t;

  vec_t vecs[10];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive(input int w, input logic st, input logic sb, input logic ci,
                       input logic [7:0] aa, input logic [7:0] bb);
    if (w == 8) begin
      s8_start = st; s8_sub = sb; s8_cin = ci; s8_a = aa; s8_b = bb;
    end else begin
      s2_start = st; s2_sub = sb; s2_cin = ci; s2_a = aa; s2_b = bb;
    end
  endtask

  function automatic logic get_done(input int w);
    return (w == 8) ? o8_done : o2_done;
  endfunction

  function automatic logic get_busy(input int w);
    return (w == 8) ? o8_busy : o2_busy;
  endfunction

  function automatic logic [9:0] get_res(input int w);
    return (w == 8) ? {o8_ovf, o8_cout, o8_sum} : {o2_ovf, o2_cout, o2_sum};
  endfunction

  // Called at the negedge after start is sampled; returns at the negedge where done is seen.
  task automatic wait_done(input int w, output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (!get_done(w) && lat < 20) begin
      if (get_busy(w)) bc++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_result(input int w, input string tag, input logic [7:0] es,
                              input logic ec, input logic eo);
    logic [9:0] r;
    r = get_res(w);
    chk({tag, "_sum"},  32'(r[7:0]), 32'(es));
    chk({tag, "_cout"}, 32'(r[8]),   32'(ec));
    chk({tag, "_ovf"},  32'(r[9]),   32'(eo & OVF_EN));
    chk({tag, "_busy_at_done"}, 32'(get_busy(w)), 32'd0);
  endtask

  task automatic run_vec(input int w, input vec_t v, input string tag);
    int lat, bc;
    @(negedge clk);
    drive(w, 1'b1, v.sub, v.cin, v.a, v.b);
    @(negedge clk);
    drive(w, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    wait_done(w, lat, bc);
    chk({tag, "_latency"}, 32'(lat), (w == 8) ? 32'd1 : 32'd4);
    chk({tag, "_busy_cycles"}, 32'(bc), (w == 8) ? 32'd1 : 32'd4);
    check_result(w, tag, v.exp_sum, v.exp_cout, v.exp_ovf);
    @(negedge clk);
    chk({tag, "_done_pulse"}, 32'(get_done(w)), 32'd0);
  endtask

  initial begin
    int lat, bc;
    vec_t v;
    //         sub   cin   a      b      sum    cout  ovf
    vecs[0] = '{1'b0, 1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0};
    vecs[1] = '{1'b1, 1'b0, 8'h05, 8'h07, 8'hFE, 1'b0, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1};
    vecs[3] = '{1'b0, 1'b1, 8'h11, 8'h22, 8'h34, 1'b0, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 1'b1, 8'hA5, 8'h5A, 8'h00, 1'b1, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1};
    vecs[7] = '{1'b1, 1'b0, 8'h33, 8'h33, 8'h00, 1'b1, 1'b0};
    vecs[8] = '{1'b0, 1'b0, 8'h80, 8'h80, 8'h00, 1'b1, 1'b1};
    vecs[9] = '{1'b1, 1'b1, 8'h10, 8'h01, 8'h0F, 1'b1, 1'b0};

    drive(2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    drive(8, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    #12;
    chk("rst_w2_outputs", 32'({o2_ovf, o2_cout, o2_sum, o2_busy, o2_done}), 32'd0);
    chk("rst_w8_outputs", 32'({o8_ovf, o8_cout, o8_sum, o8_busy, o8_done}), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_vec(2, vecs[i], $sformatf("v%0d_w2", i));
      run_vec(8, vecs[i], $sformatf("v%0d_w8", i));
    end

    // start while busy is ignored; start in the done cycle is accepted
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 1'b0, 8'hFF, 8'h01);
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 1'b1, 8'h11, 8'h22);
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    wait_done(2, lat, bc);
    chk("repulse_latency", 32'(lat), 32'd3);
    check_result(2, "repulse", 8'h00, 1'b1, 1'b0);
    drive(2, 1'b1, 1'b0, 1'b1, 8'h11, 8'h22);
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    chk("donecyc_sum_held", 32'(o2_sum), 32'h00);
    chk("donecyc_done_low", 32'(o2_done), 32'd0);
    chk("donecyc_busy", 32'(o2_busy), 32'd1);
    wait_done(2, lat, bc);
    chk("donecyc_latency", 32'(lat), 32'd4);
    check_result(2, "donecyc", 8'h34, 1'b0, 1'b0);

    // reset two cycles into RUN abandons the operation
    @(negedge clk);
    drive(2, 1'b1, 1'b0, 1'b0, 8'h55, 8'h55);
    @(negedge clk);
    drive(2, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    chk("midrst_busy_before", 32'(o2_busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("midrst_outputs", 32'({o2_ovf, o2_cout, o2_sum, o2_busy, o2_done}), 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk($sformatf("midrst_hold%0d", i), 32'({o2_ovf, o2_cout, o2_sum, o2_busy, o2_done}), 32'd0);
    end
    rst = 1'b0;
    v = '{1'b0, 1'b0, 8'h10, 8'h20, 8'h30, 1'b0, 1'b0};
    run_vec(2, v, "postrst");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
